// File: rtl/srl_fifo_pkg.sv
// Shared sizing helpers for the SRL FIFO array: clog2 and the address/count width rules.
package srl_fifo_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int addr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // Count must represent DEPTH+1 when the output register is enabled.
    function automatic int count_width(input int depth);
        return clog2(depth + 2);
    endfunction

endpackage

// File: rtl/srl_fifo_array_if.sv
// Packed multi-lane FIFO handshake bus; lane i occupies slice i of every vector.
interface srl_fifo_array_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CHANNELS   = 4
);
    localparam int CW = srl_fifo_pkg::count_width(DEPTH);

    logic [CHANNELS-1:0]            if_write;
    logic [CHANNELS*DATA_WIDTH-1:0] if_din;
    logic [CHANNELS-1:0]            if_full_n;
    logic [CHANNELS-1:0]            if_read;
    logic [CHANNELS*DATA_WIDTH-1:0] if_dout;
    logic [CHANNELS-1:0]            if_empty_n;
    logic [CHANNELS-1:0]            almost_full;
    logic [CHANNELS*CW-1:0]         count;

    modport master (
        output if_write, if_din, if_read,
        input  if_full_n, if_dout, if_empty_n, almost_full, count
    );

    modport slave (
        input  if_write, if_din, if_read,
        output if_full_n, if_dout, if_empty_n, almost_full, count
    );

endinterface

// File: rtl/srl_fifo_lane.sv
// One SRL FIFO lane: shift storage, occupancy counter, registered flags, optional output register.
module srl_fifo_lane
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter bit OUT_REG    = 1'b0,
    parameter int AW         = addr_width(DEPTH),
    parameter int CW         = count_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full_n,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty_n,
    output logic                  almost_full,
    output logic [CW-1:0]         count
);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);

    logic [DATA_WIDTH-1:0] srl [DEPTH];
    logic [CW-1:0]         srl_cnt, srl_cnt_nxt, count_nxt, count_q;
    logic [AW-1:0]         ptr;
    logic                  push, pop, load;
    logic                  oreg_v, oreg_v_nxt;
    logic [DATA_WIDTH-1:0] oreg;
    logic                  full_n_q, empty_n_q, af_q;

    assign push = write & full_n_q;
    assign pop  = read & empty_n_q;
    assign ptr  = (srl_cnt == '0) ? '0 : AW'(srl_cnt - ONE);

    always_comb begin
        load        = 1'b0;
        oreg_v_nxt  = oreg_v;
        srl_cnt_nxt = srl_cnt;
        if (OUT_REG) begin
            // Refill the output register whenever it is free or being consumed.
            load = (!oreg_v || pop) && (srl_cnt != '0);
            if (load)
                oreg_v_nxt = 1'b1;
            else if (pop)
                oreg_v_nxt = 1'b0;
            if (push && !load)
                srl_cnt_nxt = srl_cnt + ONE;
            else if (!push && load)
                srl_cnt_nxt = srl_cnt - ONE;
        end else begin
            if (push && !pop)
                srl_cnt_nxt = srl_cnt + ONE;
            else if (!push && pop)
                srl_cnt_nxt = srl_cnt - ONE;
        end
        count_nxt = srl_cnt_nxt + CW'(oreg_v_nxt);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            srl[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                srl[i] <= srl[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            srl_cnt   <= '0;
            oreg_v    <= 1'b0;
            oreg      <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            af_q      <= 1'b0;
            count_q   <= '0;
        end else begin
            srl_cnt   <= srl_cnt_nxt;
            oreg_v    <= oreg_v_nxt;
            if (load)
                oreg <= srl[ptr];
            full_n_q  <= (srl_cnt_nxt != CNT_FULL);
            empty_n_q <= OUT_REG ? oreg_v_nxt : (srl_cnt_nxt != '0);
            af_q      <= (count_nxt >= CNT_AF);
            count_q   <= count_nxt;
        end
    end

    assign full_n      = full_n_q;
    assign empty_n     = empty_n_q;
    assign almost_full = af_q;
    assign count       = count_q;
    assign dout        = OUT_REG ? oreg : srl[ptr];

endmodule

// File: rtl/srl_fifo_array.sv
// CHANNELS independent SRL FIFO lanes sharing one packed handshake bus.
module srl_fifo_array
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CHANNELS   = 4,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter bit OUT_REG    = 1'b0
) (
    input logic             clk,
    input logic             reset_n,
    srl_fifo_array_if.slave bus
);

    localparam int CW = count_width(DEPTH);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        srl_fifo_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .AF_LEVEL   (AF_LEVEL),
            .OUT_REG    (OUT_REG)
        ) u_lane (
            .clk         (clk),
            .reset_n     (reset_n),
            .write       (bus.if_write[i]),
            .din         (bus.if_din[i*DATA_WIDTH +: DATA_WIDTH]),
            .full_n      (bus.if_full_n[i]),
            .read        (bus.if_read[i]),
            .dout        (bus.if_dout[i*DATA_WIDTH +: DATA_WIDTH]),
            .empty_n     (bus.if_empty_n[i]),
            .almost_full (bus.almost_full[i]),
            .count       (bus.count[i*CW +: CW])
        );
    end

endmodule

// File: doc/srl_fifo_array.md
# srl_fifo_array

Parametrised array of CHANNELS independent shift-register (SRL) FIFOs with full_n/empty_n handshakes, per-lane occupancy count, almost-full flag and optional registered output. It is the successor to the single-lane fixed-depth shift register behind the generated start/stream FIFOs. It sits between PE arrays and their feeders/drainers in the linear-layer datapath, replacing per-channel hand-instantiated FIFOs.

## Interface
- DATA_WIDTH, 8, bits per entry per lane (>=1)
- DEPTH, 16, SRL entries per lane (>=2)
- CHANNELS, 4, number of independent lanes (>=1)
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- OUT_REG, 0, 0 = fall-through from SRL; 1 = extra output register stage
- Derived: AW = max(1, clog2(DEPTH)); CW = clog2(DEPTH+2)
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_write  in  CHANNELS  per-lane write request
- if_din  in  CHANNELS*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- if_full_n  out  CHANNELS  lane can accept a write
- if_read  in  CHANNELS  per-lane read request
- if_dout  out  CHANNELS*DATA_WIDTH  lane head data, packed as if_din
- if_empty_n  out  CHANNELS  lane head valid
- almost_full  out  CHANNELS  count >= AF_LEVEL
- count  out  CHANNELS*CW  lane occupancy, including output register when OUT_REG=1

## Operation
- Lanes are fully independent; no cross-lane coupling.
- Push = if_write & if_full_n (registered full_n; write while full_n=0 is dropped, even with a simultaneous read).
- Pop = if_read & if_empty_n (read while empty is ignored).
- SRL storage: on push, all entries shift by one and din enters entry 0; storage is never reset.
- Read address ptr = srl_cnt-1; head = SRL[ptr].
- OUT_REG=0: srl_cnt changes +1 push only, -1 pop only, unchanged on both; if_dout = SRL[ptr] combinationally; capacity DEPTH.
- OUT_REG=1: output register (oreg, oreg_v) holds head. Each cycle, if (!oreg_v or pop) and srl_cnt>0, SRL[ptr] moves to oreg and srl_cnt decrements (a simultaneous push increments it, net 0). if_full_n is derived from srl_cnt only; capacity DEPTH+1. No bypass from din to oreg.
- count = srl_cnt (+ oreg_v when OUT_REG=1); almost_full computed from the next-state count and registered.
- Simultaneous push+pop at full: pop only (the push is dropped per full_n rule). At empty: push only.
- Reset: srl_cnt=0, ptr=0, oreg_v=0, oreg=0, if_full_n=1, if_empty_n=0, almost_full=0, count=0.
- if_dout is don't-care while if_empty_n=0; it is 0 after reset with OUT_REG=1.

## Timing
- All flags are registered; no combinational path from if_write/if_read to any flag.
- OUT_REG=0: write at edge k makes if_empty_n=1 and if_dout valid after edge k (latency 1).
- OUT_REG=1: write into an empty lane makes if_empty_n=1 after edge k+1 (latency 2).
- if_full_n falls after the edge where srl_cnt reaches DEPTH, and rises after the first pop edge that leaves srl_cnt < DEPTH.
- Throughput: 1 push and 1 pop per lane per cycle sustained at any occupancy 0<count<capacity.
- Asynchronous reset mid-operation: all lanes clear immediately; any data in flight is discarded; the first legal push is at the first edge after deassertion.

## Structure
- Package srl_fifo_pkg: the clog2 function, and the AW/CW derivation rule.
- Sub-module srl_fifo_lane holds one lane (SRL storage, counter, flags, optional oreg). Top srl_fifo_array is a generate loop of CHANNELS lanes plus bus slicing only.

## Test plan
- Reset, DEPTH=16, OUT_REG=0: reset_n low -> if_full_n=all 1, if_empty_n=0, count=0, almost_full=0.
- Lane 0: write 0x01..0x10 back-to-back -> if_full_n[0]=0 after 16th edge; 17th write 0x11 dropped; reads return 0x01..0x10 in order, then if_empty_n[0]=0.
- Simultaneous push+pop at count=5 for 100 cycles -> count stays 5, data order preserved; at full, push+pop -> count 15, pushed value dropped.
- AF_LEVEL=14: fill to 13 -> almost_full=0; 14th write -> almost_full=1 after that edge.
- OUT_REG=1: single write 0xA5 at edge k -> if_empty_n=1 after k+1, dout=0xA5; fill to 17 -> if_full_n=0 at count=17.
- CHANNELS=4 random independent traffic with reset_n pulsed low mid-stream -> scoreboard per lane matches; after reset all counts=0, no stale data is read.
